// File: rtl/timer_core_if.sv
// Register-file <-> counting-engine link: field values out of the file and
// next-value / interrupt signals back into it, named from the core's side.
interface timer_core_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] pre_i;
  logic [WIDTH-1:0] are_i;
  logic             clr_i;
  logic             ena_i;
  logic             mod_i;
  logic [WIDTH-1:0] cnt_i;
  logic [WIDTH-1:0] evn_i;
  logic             evc_i;
  logic             clr_o;
  logic [WIDTH-1:0] cnt_o;
  logic [WIDTH-1:0] evn_o;
  logic             evc_o;
  logic             irq_o;

  // Register-file side
  modport master (
    output pre_i, are_i, clr_i, ena_i, mod_i, cnt_i, evn_i, evc_i,
    input  clr_o, cnt_o, evn_o, evc_o, irq_o
  );

  // Counting-engine side
  modport slave (
    input  pre_i, are_i, clr_i, ena_i, mod_i, cnt_i, evn_i, evc_i,
    output clr_o, cnt_o, evn_o, evc_o, irq_o
  );
endinterface

// File: rtl/timer_core.sv
// Timer counting engine: prescaler, run/one-shot state and irq flop; next-value
// outputs feed straight back into the register file that owns CNT/EVN/EVC.
module timer_core #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          EVN_SAT = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  timer_core_if.slave   tmr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] psc_q, psc_d;
  logic             irq_q, irq_d;

  logic             tick;
  logic             match;
  logic             evt;
  logic [WIDTH-1:0] evn_inc;

  // A pending clear suppresses the tick so clear always wins over an event.
  always_comb begin
    tick  = (state_q == ST_RUN) && !tmr.clr_i && (psc_q >= tmr.pre_i);
    match = (tmr.cnt_i >= tmr.are_i);
    evt   = tick && match;
    if (EVN_SAT && (&tmr.evn_i)) begin
      evn_inc = tmr.evn_i;
    end else begin
      evn_inc = tmr.evn_i + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      psc_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    psc_d   = '0;
    irq_d   = evt;

    unique case (state_q)
      ST_IDLE: begin
        if (tmr.ena_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!tmr.ena_i) begin
          state_d = ST_IDLE;
        end else if (evt && !tmr.mod_i) begin
          state_d = ST_DONE;
        end
        if (!tmr.clr_i && !tick) begin
          psc_d = psc_q + WIDTH'(1);
        end
      end
      ST_DONE: begin
        if (!tmr.ena_i) begin
          state_d = ST_IDLE;
        end else if (tmr.clr_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs default to the current register contents so the file holds
  // its value on idle cycles and throughout reset.
  always_comb begin
    tmr.cnt_o = tmr.cnt_i;
    tmr.evn_o = tmr.evn_i;
    tmr.evc_o = tmr.evc_i;
    tmr.clr_o = 1'b0;

    if (rst_ni) begin
      if (tmr.clr_i) begin
        tmr.cnt_o = '0;
      end else if (evt) begin
        tmr.cnt_o = tmr.mod_i ? '0 : tmr.are_i;
        tmr.evn_o = evn_inc;
        tmr.evc_o = 1'b1;
      end else if (tick) begin
        tmr.cnt_o = tmr.cnt_i + WIDTH'(1);
      end
    end
  end

  assign tmr.irq_o = irq_q;

endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: a behavioural register file around the
// core, plus an independent model of CNT/EVN/EVC/CLR/irq derived from the rules.
module tb_timer_core;

  localparam int unsigned W   = 32;
  localparam bit          SAT = 1'b1;
  localparam logic [W-1:0] ALL1 = '1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  timer_core_if #(.WIDTH(W)) tif ();

  timer_core #(.WIDTH(W), .EVN_SAT(SAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .tmr    (tif)
  );

  // Control fields and bus-write strobes driven by the tests
  logic [W-1:0] pre = '0;
  logic [W-1:0] are = '0;
  logic         ena = 1'b0;
  logic         mod = 1'b0;
  logic         wr_cnt = 1'b0, wr_evn = 1'b0, wr_evc = 1'b0, wr_clr = 1'b0;
  logic [W-1:0] wd_cnt = '0, wd_evn = '0;
  logic         wd_evc = 1'b0;

  // Register file: bus writes override the core's next values
  logic [W-1:0] r_cnt = '0;
  logic [W-1:0] r_evn = '0;
  logic         r_evc = 1'b0;
  logic         r_clr = 1'b0;

  always @(posedge clk) begin
    r_cnt <= wr_cnt ? wd_cnt : tif.cnt_o;
    r_evn <= wr_evn ? wd_evn : tif.evn_o;
    r_evc <= wr_evc ? wd_evc : tif.evc_o;
    r_clr <= wr_clr ? 1'b1   : tif.clr_o;
  end

  assign tif.pre_i = pre;
  assign tif.are_i = are;
  assign tif.ena_i = ena;
  assign tif.mod_i = mod;
  assign tif.clr_i = r_clr;
  assign tif.cnt_i = r_cnt;
  assign tif.evn_i = r_evn;
  assign tif.evc_i = r_evc;

  // Reference model: running/expired flags, clocks since last tick, and
  // its own copy of the architectural registers.
  logic         m_run = 1'b0, m_done = 1'b0;
  int unsigned  m_phase = 0;
  logic [W-1:0] m_cnt = '0;
  logic [W-1:0] m_evn = '0;
  logic         m_evc = 1'b0;
  logic         m_clr = 1'b0;
  logic         m_irq = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic         t, e, c;
    logic [W-1:0] nc, ne;
    if (!rst_n) begin
      m_run   = 1'b0;
      m_done  = 1'b0;
      m_phase = 0;
      m_irq   = 1'b0;
      m_clr   = 1'b0;
    end else begin
      c = m_clr;
      t = m_run && !c && (W'(m_phase) >= pre);
      e = t && (m_cnt >= are);
      if (c)      nc = '0;
      else if (e) nc = mod ? '0 : are;
      else if (t) nc = m_cnt + 1;
      else        nc = m_cnt;
      if (e) ne = (SAT && m_evn == ALL1) ? m_evn : m_evn + 1;
      else   ne = m_evn;
      m_phase = (m_run && !c && !t) ? m_phase + 1 : 0;
      if (m_run) begin
        if (!ena) m_run = 1'b0;
        else if (e && !mod) begin m_run = 1'b0; m_done = 1'b1; end
      end else if (m_done) begin
        if (!ena) m_done = 1'b0;
        else if (c) begin m_done = 1'b0; m_run = 1'b1; end
      end else if (ena) begin
        m_run = 1'b1;
      end
      m_irq = e;
      m_cnt = wr_cnt ? wd_cnt : nc;
      m_evn = wr_evn ? wd_evn : ne;
      m_evc = wr_evc ? wd_evc : (m_evc | e);
      m_clr = wr_clr;
    end
  end

  logic [2*W+2:0] obs_v, exp_v;
  assign obs_v = {r_cnt, r_evn, r_evc, r_clr, tif.irq_o};
  assign exp_v = {m_cnt, m_evn, m_evc, m_clr, m_irq};

  int n_checks = 0;
  int n_errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    wr_cnt = 1'b0; wr_evn = 1'b0; wr_evc = 1'b0; wr_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (tif.irq_o !== 1'b0) begin
      $display("FAIL reset_irq: got %b expected 0", tif.irq_o); n_errors++;
    end
    n_checks++;
    if ({tif.cnt_o, tif.evn_o, tif.evc_o, tif.clr_o} !== {m_cnt, m_evn, m_evc, 1'b0}) begin
      $display("FAIL reset_passthru: got %h/%h/%b/%b expected %h/%h/%b/0",
               tif.cnt_o, tif.evn_o, tif.evc_o, tif.clr_o, m_cnt, m_evn, m_evc);
      n_errors++;
    end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++;
    if (obs_v !== exp_v) begin
      $display("FAIL reset_state: got %h expected %h", obs_v, exp_v); n_errors++;
    end
  endtask

  task automatic test_periodic();
    ena = 1'b0; cyc();
    pre = 0; are = 3; mod = 1'b1; ena = 1'b1;
    wr_cnt = 1'b1; wd_cnt = '0; wr_evn = 1'b1; wd_evn = '0; wr_evc = 1'b1; wd_evc = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      n_checks++;
      if (obs_v !== exp_v) begin
        $display("FAIL periodic[%0d]: got %h expected %h", i, obs_v, exp_v); n_errors++;
      end
    end
    // 14 edges: 1 start edge + 13 ticks through 0..3 -> three 3->0 wraps
    n_checks++;
    if ({r_cnt, r_evn, r_evc} !== {32'd1, 32'd3, 1'b1}) begin
      $display("FAIL periodic_end: got cnt=%0d evn=%0d evc=%b expected cnt=1 evn=3 evc=1",
               r_cnt, r_evn, r_evc);
      n_errors++;
    end
  endtask

  task automatic test_prescale();
    ena = 1'b0; cyc();
    pre = 2; are = 100; mod = 1'b1; ena = 1'b1;
    wr_cnt = 1'b1; wd_cnt = '0;
    for (int i = 0; i < 31; i++) begin
      cyc();
      n_checks++;
      if (obs_v !== exp_v || tif.irq_o !== 1'b0) begin
        $display("FAIL prescale[%0d]: got %h expected %h", i, obs_v, exp_v); n_errors++;
      end
    end
    // start edge, then ticks on every third edge: 30 edges -> 10 ticks
    n_checks++;
    if (r_cnt !== 32'd10) begin
      $display("FAIL prescale_cnt: got %0d expected 10", r_cnt); n_errors++;
    end
  endtask

  task automatic test_oneshot();
    logic [W-1:0] evn0;
    ena = 1'b0; cyc();
    pre = 0; are = 2; mod = 1'b0; ena = 1'b1;
    wr_cnt = 1'b1; wd_cnt = '0;
    evn0 = m_evn;
    for (int i = 0; i < 8; i++) begin
      cyc();
      n_checks++;
      if (obs_v !== exp_v) begin
        $display("FAIL oneshot[%0d]: got %h expected %h", i, obs_v, exp_v); n_errors++;
      end
    end
    n_checks++;
    if ({r_cnt, r_evn} !== {32'd2, evn0 + 32'd1}) begin
      $display("FAIL oneshot_hold: got cnt=%0d evn=%0d expected cnt=2 evn=%0d",
               r_cnt, r_evn, evn0 + 32'd1);
      n_errors++;
    end
    wr_clr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_checks++;
      if (obs_v !== exp_v) begin
        $display("FAIL oneshot_restart[%0d]: got %h expected %h", i, obs_v, exp_v); n_errors++;
      end
    end
  endtask

  task automatic test_clear_vs_tick();
    logic [W-1:0] evn0;
    ena = 1'b0; cyc();
    pre = 0; are = 5; mod = 1'b1; ena = 1'b1;
    wr_cnt = 1'b1; wd_cnt = '0;
    cyc();
    wr_cnt = 1'b1; wd_cnt = 5; wr_clr = 1'b1;
    cyc();
    evn0 = r_evn;
    n_checks++;
    if ({tif.cnt_o, tif.clr_o, tif.evn_o} !== {32'd0, 1'b0, evn0}) begin
      $display("FAIL clear_beats_tick: got cnt_o=%h clr_o=%b evn_o=%h expected 0/0/%h",
               tif.cnt_o, tif.clr_o, tif.evn_o, evn0);
      n_errors++;
    end
    cyc();
    n_checks++;
    if (obs_v !== exp_v || tif.irq_o !== 1'b0) begin
      $display("FAIL clear_no_irq: got %h expected %h", obs_v, exp_v); n_errors++;
    end
  endtask

  task automatic test_overshoot_sat();
    ena = 1'b0; cyc();
    pre = 0; are = 5; mod = 1'b1; ena = 1'b1;
    wr_cnt = 1'b1; wd_cnt = 10; wr_evn = 1'b1; wd_evn = ALL1;
    cyc();
    cyc();
    n_checks++;
    if ({r_cnt, r_evn, r_evc, tif.irq_o} !== {32'd0, ALL1, 1'b1, 1'b1}) begin
      $display("FAIL overshoot_sat: got cnt=%h evn=%h evc=%b irq=%b expected 0/ffffffff/1/1",
               r_cnt, r_evn, r_evc, tif.irq_o);
      n_errors++;
    end
    cyc();
    n_checks++;
    if (obs_v !== exp_v || tif.irq_o !== 1'b0) begin
      $display("FAIL irq_one_cycle: got %h expected %h", obs_v, exp_v); n_errors++;
    end
  endtask

  task automatic test_reset_midcount();
    ena = 1'b0; cyc();
    pre = 3; are = 50; mod = 1'b1; ena = 1'b1;
    wr_cnt = 1'b1; wd_cnt = '0;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tif.irq_o !== 1'b0 || tif.cnt_o !== r_cnt) begin
      $display("FAIL reset_mid: got irq=%b cnt_o=%h expected 0/%h", tif.irq_o, tif.cnt_o, r_cnt);
      n_errors++;
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_checks++;
      if (obs_v !== exp_v) begin
        $display("FAIL reset_resume[%0d]: got %h expected %h", i, obs_v, exp_v); n_errors++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      pre = W'($urandom_range(0, 3));
      are = W'($urandom_range(0, 7));
      mod = 1'($urandom_range(0, 3) != 0);
      ena = 1'($urandom_range(0, 9) != 0);
      wr_clr = 1'($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) begin wr_cnt = 1'b1; wd_cnt = W'($urandom_range(0, 10)); end
      if ($urandom_range(0, 49) == 0) begin wr_evn = 1'b1; wd_evn = ALL1 - W'($urandom_range(0, 2)); end
      if ($urandom_range(0, 24) == 0) begin wr_evc = 1'b1; wd_evc = 1'b0; end
      cyc();
      n_checks++;
      if (obs_v !== exp_v) begin
        $display("FAIL random[%0d]: got %h expected %h", i, obs_v, exp_v); n_errors++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_prescale();
    test_oneshot();
    test_clear_vs_tick();
    test_overshoot_sat();
    test_reset_midcount();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
